// File: rtl/fir_pkg.sv
// Shared FIR constants: coefficient width, coefficient table and the MAC FSM states.
package fir_pkg;
  localparam int BW_COEF = 4;
  localparam int N_COEF  = 10;
  localparam int COEF_IW = $clog2(N_COEF);

  localparam logic signed [BW_COEF-1:0] COEF [N_COEF] = '{
    4'sd1, 4'sd2, 4'sd3, 4'sd4, 4'sd5, 4'sd5, 4'sd4, 4'sd3, 4'sd2, 4'sd1
  };

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} fir_state_t;
endpackage

// File: rtl/fir_coef_rom.sv
// Combinational coefficient lookup; indices past the tap count (or the table) read as 0.
module fir_coef_rom
  import fir_pkg::*;
#(
  parameter int N_TAPS = 10,
  parameter int IDX_W  = 4
) (
  input  logic [IDX_W-1:0]          idx,
  output logic signed [BW_COEF-1:0] coef
);
  always_comb begin
    coef = '0;
    if (int'(idx) < N_TAPS && int'(idx) < N_COEF)
      coef = COEF[COEF_IW'(idx)];
  end
endmodule

// File: rtl/fir_mac_seq.sv
// Sequential single-MAC FIR: snapshots the delay line, accumulates one tap per cycle.
// Define FIR_MAC_SATURATE_EN to clamp the shifted result instead of wrapping it.
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter int N_TAPS = 10,
  parameter int BW_in  = 2,
  parameter int BW_out = 4,
  parameter int SHIFT  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_TAPS*BW_in-1:0]   taps,
  input  logic                      sample_valid,
  output logic signed [BW_out-1:0]  y_out,
  output logic                      y_valid,
  output logic                      busy,
  output logic                      overrun
);
  localparam int IDX_W = (N_TAPS > 1) ? $clog2(N_TAPS + 1) : 1;
  localparam int ACC_W = BW_in + BW_COEF + $clog2(N_TAPS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_TAPS - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((2 ** (BW_out - 1)) - 1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  fir_state_t state, state_nxt;
  logic [N_TAPS-1:0][BW_in-1:0] snap;
  logic [IDX_W-1:0]             idx;
  logic signed [ACC_W-1:0]      acc, term, shifted;
  logic signed [BW_in-1:0]      tap_s;
  logic signed [BW_COEF-1:0]    coef;
  logic signed [BW_out-1:0]     y_nxt;
  logic                         start;

  fir_coef_rom #(.N_TAPS(N_TAPS), .IDX_W(IDX_W)) u_rom (
    .idx  (idx),
    .coef (coef)
  );

  always_comb begin
    tap_s = '0;
    if (int'(idx) < N_TAPS) tap_s = snap[idx];
    term    = ACC_W'(tap_s) * ACC_W'(coef);
    shifted = acc >>> SHIFT;
    y_nxt   = shifted[BW_out-1:0];
`ifdef FIR_MAC_SATURATE_EN
    if (shifted > OUT_MAX)      y_nxt = OUT_MAX[BW_out-1:0];
    else if (shifted < OUT_MIN) y_nxt = OUT_MIN[BW_out-1:0];
`endif
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    start     = 1'b0;
    case (state)
      IDLE: if (sample_valid) begin
        start     = 1'b1;
        state_nxt = ACCUM;
      end
      ACCUM: begin
        busy = 1'b1;
        if (idx == LAST) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
        if (sample_valid) begin
          start     = 1'b1;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      snap    <= '0;
      acc     <= '0;
      idx     <= '0;
      y_out   <= '0;
      y_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      // acc is final while in DONE, so the result is published one cycle after the last term
      y_valid <= (state == DONE);
      if (state == DONE) y_out <= y_nxt;
      if (start) begin
        snap <= taps;
        acc  <= '0;
        idx  <= '0;
      end else if (state == ACCUM) begin
        acc <= acc + term;
        idx <= idx + 1'b1;
      end
      if (state == ACCUM && sample_valid) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fir_mac_seq.sv
// Randomized and directed checks of fir_mac_seq against a plain-arithmetic dot-product model.
module tb_fir_mac_seq;
  localparam int N  = 10;
  localparam int BW = 2;
  localparam int BO = 4;
  localparam int SH = 2;
  localparam int TW = N * BW;

  logic clk = 1'b0;
  logic reset;
  logic [TW-1:0] taps;
  logic sample_valid;
  logic signed [BO-1:0] y_out;
  logic y_valid, busy, overrun;

  int total = 0;
  int bad   = 0;
  int coef_ref [N] = '{1, 2, 3, 4, 5, 5, 4, 3, 2, 1};

  fir_mac_seq #(.N_TAPS(N), .BW_in(BW), .BW_out(BO), .SHIFT(SH)) dut (
    .clk          (clk),
    .reset        (reset),
    .taps         (taps),
    .sample_valid (sample_valid),
    .y_out        (y_out),
    .y_valid      (y_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int ref_y(input logic [TW-1:0] t);
    int s;
    logic signed [BW-1:0] v;
    logic signed [BO-1:0] w;
    s = 0;
    for (int i = 0; i < N; i++) begin
      v = t[i*BW +: BW];
      s += int'(v) * coef_ref[i];
    end
    s = s >>> SH;
`ifdef FIR_MAC_SATURATE_EN
    if (s > 2 ** (BO - 1) - 1) s = 2 ** (BO - 1) - 1;
    if (s < -(2 ** (BO - 1)))  s = -(2 ** (BO - 1));
    return s;
`else
    w = s[BO-1:0];
    return int'(w);
`endif
  endfunction

  task automatic fire(input logic [TW-1:0] t);
    taps = t;
    sample_valid = 1'b1;
    @(negedge clk);
  endtask

  // Called one negedge after the accepting edge; scrambles taps while waiting for y_valid.
  task automatic wait_yv(input int ov_at, input bit b2b, input logic [TW-1:0] t2,
                         output int lat, output int bn);
    lat = -1;
    bn  = busy ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      sample_valid = (k == ov_at) || (b2b && k == N + 1);
      taps = (b2b && k == N + 1) ? t2 : TW'($urandom);
      @(negedge clk);
      if (y_valid) begin
        lat = k;
        break;
      end
      if (busy) bn++;
    end
  endtask

  task automatic do_run(input string tag, input logic [TW-1:0] t, input int exp, input int ov_at);
    int lat, bn;
    fire(t);
    wait_yv(ov_at, 1'b0, '0, lat, bn);
    sample_valid = 1'b0;
    chk({tag, "_lat"}, lat, N + 1);
    chk({tag, "_busy"}, bn, N);
    chk({tag, "_y"}, int'(y_out), exp);
    @(negedge clk);
    chk({tag, "_pulse"}, int'(y_valid), 0);
  endtask

  initial begin
    logic [TW-1:0] t, t2;
    int lat, bn, cnt;

    reset = 1'b1;
    sample_valid = 1'b0;
    taps = '0;
    repeat (2) @(negedge clk);
    chk("rst_y", int'(y_out), 0);
    chk("rst_yv", int'(y_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovr", int'(overrun), 0);
    reset = 1'b0;
    @(negedge clk);

    do_run("ones", {N{2'b01}}, 7, 0);
    t = '0;
    t[4*BW +: BW] = 2'b01;
    do_run("tap4", t, 1, 0);
`ifdef FIR_MAC_SATURATE_EN
    do_run("neg2", {N{2'b10}}, -8, 0);
`else
    do_run("neg2", {N{2'b10}}, 1, 0);
`endif
    chk("ovr_clear", int'(overrun), 0);

    // second sample_valid mid-accumulation is dropped and flagged
    do_run("ovr", {N{2'b01}}, 7, 3);
    chk("ovr_set", int'(overrun), 1);
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (y_valid) cnt++;
    end
    chk("ovr_extra_yv", cnt, 0);
    chk("ovr_sticky", int'(overrun), 1);

    // reset during accumulation aborts it
    fire(TW'($urandom));
    sample_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_y", int'(y_out), 0);
    chk("mid_rst_yv", int'(y_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ovr", int'(overrun), 0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (y_valid || busy) cnt++;
    end
    chk("mid_rst_quiet", cnt, 0);
    t = TW'($urandom);
    do_run("post_rst", t, ref_y(t), 0);

    // back-to-back: next sample accepted in the DONE cycle
    t  = TW'($urandom);
    t2 = TW'($urandom);
    fire(t);
    wait_yv(0, 1'b1, t2, lat, bn);
    chk("b2b0_lat", lat, N + 1);
    chk("b2b0_y", int'(y_out), ref_y(t));
    wait_yv(0, 1'b0, '0, lat, bn);
    sample_valid = 1'b0;
    chk("b2b1_lat", lat, N + 1);
    chk("b2b1_busy", bn, N);
    chk("b2b1_y", int'(y_out), ref_y(t2));
    chk("b2b_ovr", int'(overrun), 0);
    @(negedge clk);

    for (int r = 0; r < 16; r++) begin
      t = TW'($urandom);
      if (r % 5 == 0) t = {N{2'b10}};
      do_run($sformatf("rnd%0d", r), t, ref_y(t), (r % 4 == 3) ? int'($urandom_range(1, N - 1)) : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fir_mac_seq.md
FIR_MAC_SEQ -- requirements
Module: fir_mac_seq

Interface
REQ-001 SHALL have parameter N_TAPS, default 10: number of taps consumed from the upstream delay line.
REQ-002 SHALL have parameter BW_in, default 2: signed width of each tap sample.
REQ-003 SHALL have parameter BW_out, default 4: signed width of y_out.
REQ-004 SHALL have parameter SHIFT, default 2: arithmetic right shift applied to the accumulator before output.
REQ-005 SHALL have one clock and an asynchronous, active-high reset; all state is reset asynchronously by reset.
REQ-006 SHALL have port clk, input, 1 bit: the single rising-edge clock.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-008 SHALL have port taps, input, N_TAPS*BW_in bits: tap i at [i*BW_in +: BW_in], tap 0 newest.
REQ-009 SHALL have port sample_valid, input, 1 bit: the delay line shifted in a new sample this cycle.
REQ-010 SHALL have port y_out, output, BW_out bits: signed filter result.
REQ-011 SHALL have port y_valid, output, 1 bit: one-cycle strobe marking a new y_out.
REQ-012 SHALL have port busy, output, 1 bit: high in ACCUM.
REQ-013 SHALL have port overrun, output, 1 bit: sticky flag for a dropped sample_valid.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM and DONE.
REQ-015 On sample_valid in IDLE or DONE, SHALL snapshot taps, clear acc and idx, and enter ACCUM.
REQ-016 In ACCUM, SHALL each cycle add signed tap[idx] times COEF[idx] to acc and increment idx.
REQ-017 After the idx=N_TAPS-1 term, SHALL enter DONE; ACCUM lasts exactly N_TAPS cycles.
REQ-018 On DONE entry, SHALL register y_out from acc>>>SHIFT reduced to BW_out bits per REQ-027, and pulse y_valid for exactly one cycle.
REQ-019 DONE without sample_valid SHALL go to IDLE; y_out holds its value until the next DONE.
REQ-020 Latency: sample_valid sampled at edge t SHALL give y_valid high in the cycle after edge t+N_TAPS+1.
REQ-021 acc SHALL be signed, BW_in+BW_COEF+$clog2(N_TAPS) bits wide, and never overflow internally.
REQ-022 sample_valid in ACCUM SHALL be ignored (no restart, snapshot unchanged) and SHALL set overrun, which stays set until reset.
REQ-023 Taps changing during ACCUM SHALL not affect the result; only the snapshot is used.

Reset
REQ-024 Reset SHALL force state=IDLE, acc=0, idx=0, y_out=0, y_valid=0, busy=0, overrun=0, and clear the snapshot to 0.
REQ-025 Reset asserted mid-ACCUM SHALL abort the computation with no y_valid; after release the block SHALL wait in IDLE for sample_valid.
REQ-026 The first sample_valid after reset release SHALL be accepted normally.

Configuration
REQ-027 With macro FIR_MAC_SATURATE_EN defined, out-of-range shifted results SHALL clamp to [-2^(BW_out-1), 2^(BW_out-1)-1]; without it, SHALL keep the low BW_out bits (two's-complement wrap).

Structure
REQ-028 Package fir_pkg SHALL hold BW_COEF (=4), the COEF array {1,2,3,4,5,5,4,3,2,1} (index 0 first) and the FSM state typedef.
REQ-029 Coefficient lookup SHALL be a sub-module fir_coef_rom: combinational, idx in, signed COEF[idx] out, returning 0 for idx >= N_TAPS.

Verification
REQ-030 All taps=1, one sample_valid -> sum 30, y_out=7, y_valid exactly 11 cycles later, busy high for 10 cycles.
REQ-031 Only tap[4]=1, others 0 -> y_out=1 (5>>>2).
REQ-032 All taps=-2 -> sum -60, shifted -15 -> y_out=-8 with FIR_MAC_SATURATE_EN, y_out=1 without.
REQ-033 sample_valid again at cycle 3 of ACCUM -> single y_valid, result of the first snapshot, overrun=1 until reset.
REQ-034 Reset at cycle 5 of ACCUM -> no y_valid, all outputs 0, next sample_valid processed normally.
REQ-035 sample_valid asserted in the DONE cycle -> back-to-back results, y_valid pulses 11 cycles apart, both correct.
